// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the register file with pending-write scoreboard.
package rf_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_NREG  = 32;
  localparam int RF_NRD   = 2;
  localparam int RF_CNTW  = 2;

  function automatic int cnt_max(input int cntw);
    return (1 << cntw) - 1;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down pending-write counter with synchronous clear and async reset.
module sb_counter
  import rf_pkg::*;
#(
  parameter int CNTW = RF_CNTW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTW-1:0] cnt
);

  localparam logic [CNTW-1:0] MAX = CNTW'(cnt_max(CNTW));

  logic dec_ok;

  // A decrement on an empty counter does not count, so a paired increment still applies
  assign dec_ok = dec && (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec_ok && (cnt != MAX)) begin
      cnt <= cnt + CNTW'(1);
    end else if (dec_ok && !inc) begin
      cnt <= cnt - CNTW'(1);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with per-register outstanding-writeback scoreboard
// so decode can detect RAW hazards directly from the read ports.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int NREG   = RF_NREG,
  parameter int NRD    = RF_NRD,
  parameter int CNTW   = RF_CNTW,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 iss_val,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_rdy,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [WIDTH-1:0]     wb_data,
  input  logic                 sb_clr,
  output logic                 sb_err
);

  localparam logic [CNTW-1:0] CMAX = CNTW'(cnt_max(CNTW));

  logic [WIDTH-1:0] rf  [NREG];
  logic [CNTW-1:0]  cnt [NREG];

  // Entry 0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  assign iss_rdy = (cnt[iss_addr] != CMAX) || (wb_en && (wb_addr == iss_addr));

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.CNTW(CNTW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (sb_clr),
      .inc   (iss_val && iss_rdy && (iss_addr == AW'(r))),
      .dec   (wb_en && (wb_addr == AW'(r))),
      .cnt   (cnt[r])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err <= 1'b0;
    end else if (wb_en && (wb_addr != '0) && (cnt[wb_addr] == '0)) begin
      sb_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          wb_hit;

    assign a      = rd_addr[i*AW +: AW];
    assign wb_hit = (BYPASS != 0) && wb_en && (wb_addr == a) && (a != '0);

    assign rd_data[i*WIDTH +: WIDTH] = wb_hit ? wb_data : rf[a];
    // The last outstanding write is being forwarded right now, so the reader need not stall
    assign rd_busy[i] = (cnt[a] != '0) && !(wb_hit && (cnt[a] == CNTW'(1)));
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: directed scoreboard scenarios plus random traffic against
// an array/integer reference model, on a bypassing and a non-bypassing instance.
module tb_regfile_sb;

  localparam int W  = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd0, rd1;
  logic          iss_val;
  logic [AW-1:0] iss_addr;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          sb_clr;

  logic [2*W-1:0] rd_data_byp, rd_data_nob;
  logic [1:0]     rd_busy_byp, rd_busy_nob;
  logic           iss_rdy_byp, iss_rdy_nob;
  logic           sb_err_byp, sb_err_nob;

  logic [W-1:0] m_rf [NR];
  int           m_cnt [NR];
  bit           m_err;

  int check_count = 0;
  int pass_count  = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .rd_addr({rd1, rd0}), .rd_data(rd_data_byp),
    .rd_busy(rd_busy_byp), .iss_val(iss_val), .iss_addr(iss_addr), .iss_rdy(iss_rdy_byp),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .sb_clr(sb_clr), .sb_err(sb_err_byp)
  );

  regfile_sb #(.BYPASS(0)) dut_nob (
    .clk(clk), .rst_n(rst_n), .rd_addr({rd1, rd0}), .rd_data(rd_data_nob),
    .rd_busy(rd_busy_nob), .iss_val(iss_val), .iss_addr(iss_addr), .iss_rdy(iss_rdy_nob),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .sb_clr(sb_clr), .sb_err(sb_err_nob)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
  endtask

  function automatic logic [W-1:0] exp_read(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && wb_en && (int'(wb_addr) == a)) return wb_data;
    return m_rf[a];
  endfunction

  function automatic bit exp_busy(input int a, input bit byp);
    if (m_cnt[a] == 0) return 1'b0;
    return !(byp && wb_en && (int'(wb_addr) == a) && (m_cnt[a] == 1));
  endfunction

  function automatic bit exp_rdy();
    return (m_cnt[iss_addr] < 3) || (wb_en && (wb_addr == iss_addr));
  endfunction

  task automatic checkAll();
    logic [AW-1:0] a;
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? rd0 : rd1;
      checkOutput($sformatf("rd_data_byp[%0d] a=%0d", p, a), rd_data_byp[p*W +: W], exp_read(int'(a), 1'b1));
      checkOutput($sformatf("rd_data_nob[%0d] a=%0d", p, a), rd_data_nob[p*W +: W], exp_read(int'(a), 1'b0));
      checkOutput($sformatf("rd_busy_byp[%0d] a=%0d", p, a), 32'(rd_busy_byp[p]), 32'(exp_busy(int'(a), 1'b1)));
      checkOutput($sformatf("rd_busy_nob[%0d] a=%0d", p, a), 32'(rd_busy_nob[p]), 32'(exp_busy(int'(a), 1'b0)));
    end
    checkOutput($sformatf("iss_rdy_byp a=%0d", iss_addr), 32'(iss_rdy_byp), 32'(exp_rdy()));
    checkOutput($sformatf("iss_rdy_nob a=%0d", iss_addr), 32'(iss_rdy_nob), 32'(exp_rdy()));
    checkOutput("sb_err_byp", 32'(sb_err_byp), 32'(m_err));
    checkOutput("sb_err_nob", 32'(sb_err_nob), 32'(m_err));
  endtask

  task automatic modelReset();
    for (int r = 0; r < NR; r++) begin
      m_rf[r]  = '0;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
  endtask

  // Outstanding count moves by +1 per accepted issue and -1 per writeback to a pending register
  task automatic modelStep();
    bit acc;
    int nc;
    acc = iss_val && exp_rdy();
    if (wb_en && (wb_addr != 0)) begin
      if (m_cnt[wb_addr] == 0) m_err = 1'b1;
      m_rf[wb_addr] = wb_data;
    end
    for (int r = 1; r < NR; r++) begin
      nc = m_cnt[r];
      if (acc && (int'(iss_addr) == r)) nc = nc + 1;
      if (wb_en && (int'(wb_addr) == r) && (m_cnt[r] > 0)) nc = nc - 1;
      m_cnt[r] = sb_clr ? 0 : nc;
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                               input logic iv, input logic [AW-1:0] ia,
                               input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                               input logic clr);
    rd0 = r0; rd1 = r1; iss_val = iv; iss_addr = ia;
    wb_en = we; wb_addr = wa; wb_data = wd; sb_clr = clr;
    @(negedge clk);
    checkAll();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    applyStimulus(r0, r1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic resetDut();
    iss_val = 1'b0; wb_en = 1'b0; sb_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; rd0 = '0; rd1 = '0; iss_val = 1'b0; iss_addr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; sb_clr = 1'b0;
    modelReset();
    resetDut();

    for (int a = 0; a < NR; a++) idle(AW'(a), AW'(NR - 1 - a));

    applyStimulus(5'd5, 5'd0, 1'b0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    idle(5'd5, 5'd5);

    for (int k = 0; k < 4; k++) applyStimulus(5'd7, 5'd0, 1'b1, 5'd7, 1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(5'd7, 5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 32'(100 + k), 1'b0);
    idle(5'd7, 5'd0);

    applyStimulus(5'd9, 5'd0, 1'b1, 5'd9, 1'b0, '0, '0, 1'b0);
    applyStimulus(5'd9, 5'd0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h0000_0999, 1'b0);
    idle(5'd9, 5'd0);
    for (int k = 0; k < 3; k++) applyStimulus(5'd7, 5'd0, 1'b1, 5'd7, 1'b0, '0, '0, 1'b0);
    applyStimulus(5'd7, 5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 32'h0000_0777, 1'b0);
    idle(5'd7, 5'd0);

    applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h1, 1'b0);
    idle(5'd0, 5'd0);

    applyStimulus(5'd12, 5'd0, 1'b0, '0, 1'b1, 5'd12, 32'h1234_5678, 1'b0);
    idle(5'd12, 5'd0);
    for (int k = 0; k < 2; k++) applyStimulus(5'd3, 5'd0, 1'b1, 5'd3, 1'b0, '0, '0, 1'b0);
    applyStimulus(5'd3, 5'd7, 1'b1, 5'd3, 1'b1, 5'd3, 32'h0000_0333, 1'b1);
    idle(5'd3, 5'd9);

    resetDut();
    idle(5'd5, 5'd12);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        resetDut();
      end else begin
        applyStimulus(AW'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 7)),
                      AW'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 7)),
                      1'($urandom_range(0, 2) == 0),
                      AW'($urandom_range(0, 7)),
                      32'($urandom),
                      1'($urandom_range(0, 63) == 0));
      end
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
